// File: rtl/picosoc_debug_master.sv
// Byte-stream debug initiator for the PicoSoC iomem bus: parses R/W commands,
// arbitrates for the bus, runs one word transaction and streams back ACK/NAK plus read data.
module picosoc_debug_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        iomem_valid_o,
    output logic [3:0]  iomem_wstrb_o,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    input  logic [31:0] iomem_rdata_i,
    input  logic        iomem_ready_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_REQ, S_BUS, S_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_cmd_t;

    localparam logic [7:0]  CMD_R   = 8'h52;
    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  ACK     = 8'h06;
    localparam logic [7:0]  NAK     = 8'h15;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    bus_cmd_t    cmd;
    logic        is_write;
    logic        nak;
    logic [1:0]  byte_cnt;
    logic [2:0]  tx_idx;
    logic [15:0] to_cnt;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;
    logic [31:0] rdata_q;

    logic rx_fire;
    logic tx_fire;
    logic tx_last;

    assign rx_fire = rx_valid_i && rx_ready_o;
    assign tx_fire = tx_valid_o && tx_ready_i;
    // NAK and write responses are a single byte; a read ACK carries four more.
    assign tx_last = (nak || is_write) ? (tx_idx == 3'd0) : (tx_idx == 3'd4);

    assign iomem_addr_o  = cmd.addr;
    assign iomem_wdata_o = cmd.wdata;
    assign iomem_wstrb_o = cmd.wstrb;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cmd           <= '0;
            is_write      <= 1'b0;
            nak           <= 1'b0;
            byte_cnt      <= 2'd0;
            tx_idx        <= 3'd0;
            to_cnt        <= 16'd0;
            addr_sr       <= 32'd0;
            data_sr       <= 32'd0;
            rdata_q       <= 32'd0;
            rx_ready_o    <= 1'b0;
            tx_valid_o    <= 1'b0;
            tx_data_o     <= 8'd0;
            bus_req_o     <= 1'b0;
            iomem_valid_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // rx_ready comes up one cycle after reset release.
                    rx_ready_o <= 1'b1;
                    if (rx_fire && (rx_data_i == CMD_R || rx_data_i == CMD_W)) begin
                        state    <= S_ADDR;
                        is_write <= (rx_data_i == CMD_W);
                        byte_cnt <= 2'd0;
                        busy_o   <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_sr  <= {rx_data_i, addr_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= S_DATA;
                            end else begin
                                state      <= S_REQ;
                                rx_ready_o <= 1'b0;
                                bus_req_o  <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        data_sr  <= {rx_data_i, data_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= S_REQ;
                            rx_ready_o <= 1'b0;
                            bus_req_o  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt_i) begin
                        state         <= S_BUS;
                        iomem_valid_o <= 1'b1;
                        to_cnt        <= 16'd0;
                        cmd.addr      <= addr_sr & 32'hFFFF_FFFC;
                        cmd.wdata     <= is_write ? data_sr : 32'd0;
                        cmd.wstrb     <= is_write ? 4'hF : 4'h0;
                    end
                end
                S_BUS: begin
                    // A ready arriving on the final timeout cycle still counts as success.
                    if (iomem_ready_i || to_cnt == TO_LAST) begin
                        state         <= S_RESP;
                        iomem_valid_o <= 1'b0;
                        bus_req_o     <= 1'b0;
                        tx_valid_o    <= 1'b1;
                        tx_idx        <= 3'd0;
                        nak           <= !iomem_ready_i;
                        tx_data_o     <= iomem_ready_i ? ACK : NAK;
                        if (iomem_ready_i)
                            rdata_q <= iomem_rdata_i;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (tx_last) begin
                            state      <= S_IDLE;
                            tx_valid_o <= 1'b0;
                            tx_data_o  <= 8'd0;
                            busy_o     <= 1'b0;
                            rx_ready_o <= 1'b1;
                        end else begin
                            tx_idx    <= tx_idx + 3'd1;
                            tx_data_o <= rdata_q[{tx_idx[1:0], 3'b000} +: 8];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_debug_master.sv
// Directed bench for picosoc_debug_master: write, read, grant delay, timeout,
// garbage/backpressure and asynchronous reset mid-command.
module tb_picosoc_debug_master;

    logic        clk;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready;
    logic        bus_req_o;
    logic        bus_gnt;
    logic        iomem_valid_o;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_addr_o;
    logic [31:0] iomem_wdata_o;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rb [0:7];
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    int          vc;
    int          cnt;

    picosoc_debug_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .rx_ready_o    (rx_ready_o),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o),
        .tx_ready_i    (tx_ready),
        .bus_req_o     (bus_req_o),
        .bus_gnt_i     (bus_gnt),
        .iomem_valid_o (iomem_valid_o),
        .iomem_wstrb_o (iomem_wstrb_o),
        .iomem_addr_o  (iomem_addr_o),
        .iomem_wdata_o (iomem_wdata_o),
        .iomem_rdata_i (iomem_rdata),
        .iomem_ready_i (iomem_ready),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({rx_ready_o, tx_valid_o, tx_data_o, bus_req_o, iomem_valid_o,
                     iomem_wstrb_o, iomem_addr_o, iomem_wdata_o, busy_o});
    endfunction

    // Sends the first nb bytes of op/addr/data; caller is at a negedge.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int nb);
        logic [7:0] b [0:8];
        int n;
        b[0] = op;
        for (int i = 0; i < 4; i++) begin
            b[1+i] = a[8*i +: 8];
            b[5+i] = d[8*i +: 8];
        end
        for (int i = 0; i < nb; i++) begin
            rx_valid = 1'b1;
            rx_data  = b[i];
            n = 0;
            while (!rx_ready_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rx_accept", 128'(n < 50), 128'(1));
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Arbiter plus responder; ready_at is the 1-based valid cycle with ready (0 = never).
    task automatic run_bus(input int gnt_delay, input int ready_at,
                           input logic [31:0] rd, output int vcyc);
        bit bad;
        int n;
        bad = 1'b0;
        chk("bus_req_rise", 128'(bus_req_o), 128'(1));
        for (int i = 0; i < gnt_delay; i++) begin
            if (!bus_req_o || iomem_valid_o) bad = 1'b1;
            @(negedge clk);
        end
        chk("gnt_wait", 128'(bad), 128'(0));
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("valid_rise", 128'(iomem_valid_o), 128'(1));
        cap_addr  = iomem_addr_o;
        cap_wdata = iomem_wdata_o;
        cap_wstrb = iomem_wstrb_o;
        vcyc = 0;
        bad  = 1'b0;
        for (n = 0; n < 100; n++) begin
            if (!iomem_valid_o) break;
            vcyc++;
            if (iomem_addr_o !== cap_addr || iomem_wdata_o !== cap_wdata ||
                iomem_wstrb_o !== cap_wstrb || !bus_req_o) bad = 1'b1;
            if (vcyc == ready_at) begin
                iomem_ready = 1'b1;
                iomem_rdata = rd;
            end
            @(negedge clk);
            iomem_ready = 1'b0;
            iomem_rdata = 32'd0;
        end
        bus_gnt = 1'b0;
        chk("bus_done", 128'(n < 100), 128'(1));
        chk("bus_stable", 128'(bad), 128'(0));
        chk("bus_req_fall", 128'(bus_req_o), 128'(0));
        chk("tx_first", 128'(tx_valid_o), 128'(1));
    endtask

    // Collects response bytes into rb until tx_valid drops; toggle stalls every other cycle.
    task automatic recv(input bit toggle, output int count);
        logic [7:0] held;
        bit stalled, bad;
        int n;
        count = 0; stalled = 1'b0; bad = 1'b0; held = 8'd0;
        for (n = 0; n < 200; n++) begin
            if (stalled && !(tx_valid_o && tx_data_o == held)) bad = 1'b1;
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (tx_valid_o && tx_ready) begin
                if (count < 8) rb[count] = tx_data_o;
                count++;
                stalled = 1'b0;
            end else if (tx_valid_o) begin
                stalled = 1'b1;
                held = tx_data_o;
            end else if (count > 0) begin
                break;
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        chk("tx_done", 128'(n < 200), 128'(1));
        chk("tx_stable", 128'(bad), 128'(0));
        chk("busy_after", 128'(busy_o), 128'(0));
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
        bus_gnt = 1'b0; iomem_rdata = 32'd0; iomem_ready = 1'b0;
        #1 chk("reset_outs", outs(), 128'(0));
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 128'(rx_ready_o), 128'(1));
        chk("idle_busy", 128'(busy_o), 128'(0));

        // write, grant immediately, ready on third valid cycle
        send_cmd(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 9);
        chk("wr_busy", 128'(busy_o), 128'(1));
        chk("wr_rx_ready", 128'(rx_ready_o), 128'(0));
        run_bus(0, 3, 32'h0, vc);
        chk("wr_vcyc", 128'(vc), 128'(3));
        chk("wr_addr", 128'(cap_addr), 128'(32'h0000_0010));
        chk("wr_wdata", 128'(cap_wdata), 128'(32'hDEAD_BEEF));
        chk("wr_wstrb", 128'(cap_wstrb), 128'(4'hF));
        recv(1'b0, cnt);
        chk("wr_cnt", 128'(cnt), 128'(1));
        chk("wr_ack", 128'(rb[0]), 128'(8'h06));

        // read, zero-wait, low address bits masked
        send_cmd(8'h52, 32'h0400_0003, 32'h0, 5);
        run_bus(0, 1, 32'h1234_5678, vc);
        chk("rd_vcyc", 128'(vc), 128'(1));
        chk("rd_addr", 128'(cap_addr), 128'(32'h0400_0000));
        chk("rd_wstrb", 128'(cap_wstrb), 128'(4'h0));
        recv(1'b0, cnt);
        chk("rd_cnt", 128'(cnt), 128'(5));
        chk("rd_b0", 128'(rb[0]), 128'(8'h06));
        chk("rd_b1", 128'(rb[1]), 128'(8'h78));
        chk("rd_b2", 128'(rb[2]), 128'(8'h56));
        chk("rd_b3", 128'(rb[3]), 128'(8'h34));
        chk("rd_b4", 128'(rb[4]), 128'(8'h12));

        // grant held off for 20 cycles
        send_cmd(8'h52, 32'h0000_0020, 32'h0, 5);
        run_bus(20, 2, 32'hCAFE_F00D, vc);
        chk("gd_vcyc", 128'(vc), 128'(2));
        recv(1'b0, cnt);
        chk("gd_cnt", 128'(cnt), 128'(5));
        chk("gd_b1", 128'(rb[1]), 128'(8'h0D));
        chk("gd_b4", 128'(rb[4]), 128'(8'hCA));

        // timeout with no ready at all
        send_cmd(8'h52, 32'h0000_0040, 32'h0, 5);
        run_bus(0, 0, 32'h0, vc);
        chk("to_vcyc", 128'(vc), 128'(16));
        recv(1'b0, cnt);
        chk("to_cnt", 128'(cnt), 128'(1));
        chk("to_nak", 128'(rb[0]), 128'(8'h15));

        // ready on the final timeout cycle wins
        send_cmd(8'h52, 32'h0000_0044, 32'h0, 5);
        run_bus(0, 16, 32'hA5A5_5A5A, vc);
        chk("tl_vcyc", 128'(vc), 128'(16));
        recv(1'b0, cnt);
        chk("tl_cnt", 128'(cnt), 128'(5));
        chk("tl_b0", 128'(rb[0]), 128'(8'h06));
        chk("tl_b1", 128'(rb[1]), 128'(8'h5A));
        chk("tl_b4", 128'(rb[4]), 128'(8'hA5));

        // garbage bytes dropped, then read under tx backpressure
        send_cmd(8'h00, 32'h0, 32'h0, 1);
        send_cmd(8'hFF, 32'h0, 32'h0, 1);
        chk("gb_busy", 128'(busy_o), 128'(0));
        chk("gb_tx", 128'(tx_valid_o), 128'(0));
        send_cmd(8'h52, 32'h0000_0008, 32'h0, 5);
        run_bus(0, 1, 32'h1122_3344, vc);
        recv(1'b1, cnt);
        chk("bp_cnt", 128'(cnt), 128'(5));
        chk("bp_b0", 128'(rb[0]), 128'(8'h06));
        chk("bp_b1", 128'(rb[1]), 128'(8'h44));
        chk("bp_b2", 128'(rb[2]), 128'(8'h33));
        chk("bp_b3", 128'(rb[3]), 128'(8'h22));
        chk("bp_b4", 128'(rb[4]), 128'(8'h11));

        // reset after two address bytes
        send_cmd(8'h57, 32'h0000_0010, 32'h0, 3);
        #2 resetn = 1'b0;
        #1 chk("rst_addr_outs", outs(), 128'(0));
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);

        // reset during BUS
        send_cmd(8'h52, 32'h0000_000C, 32'h0, 5);
        chk("rst_bus_req", 128'(bus_req_o), 128'(1));
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("rst_bus_valid", 128'(iomem_valid_o), 128'(1));
        #2 resetn = 1'b0;
        #1 chk("rst_bus_outs", outs(), 128'(0));
        bus_gnt = 1'b0;
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        chk("rst_no_tx", 128'(tx_valid_o), 128'(0));

        // full write after resets
        send_cmd(8'h57, 32'h0000_0020, 32'h1234_5678, 9);
        run_bus(0, 1, 32'h0, vc);
        chk("pw_vcyc", 128'(vc), 128'(1));
        chk("pw_addr", 128'(cap_addr), 128'(32'h0000_0020));
        chk("pw_wdata", 128'(cap_wdata), 128'(32'h1234_5678));
        recv(1'b0, cnt);
        chk("pw_cnt", 128'(cnt), 128'(1));
        chk("pw_ack", 128'(rb[0]), 128'(8'h06));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/picosoc_debug_master.md
# picosoc_debug_master

Host-driven debug initiator for the PicoSoC peripheral bus. It consumes a byte-stream command protocol, such as bytes from a UART receiver. It requests ownership of the iomem bus from an external arbiter and issues single-word iomem reads or writes as a bus initiator, sharing the bus with the picorv32. It returns an acknowledge byte plus any read data on a byte-stream output, which lets a host inspect and poke SRAM, SDRAM and A2FPGA registers without firmware cooperation.

## Interface
- TIMEOUT_CYCLES, default 1024: cycles `iomem_valid_o` may stay high without `iomem_ready_i` before the transaction is abandoned (range 2..65535).
- clk  in  1  system clock (same domain as the iomem bus).
- resetn  in  1  asynchronous, active-low reset.
- rx_valid_i  in  1  command byte available.
- rx_data_i  in  8  command byte.
- rx_ready_o  out  1  block accepts a byte this cycle.
- tx_valid_o  out  1  response byte available.
- tx_data_o  out  8  response byte.
- tx_ready_i  in  1  sink accepts the response byte.
- bus_req_o  out  1  request iomem ownership from the arbiter.
- bus_gnt_i  in  1  arbiter grant; held high while `bus_req_o` is high.
- iomem_valid_o  out  1  transaction valid.
- iomem_wstrb_o  out  4  4'hF for a write, 4'h0 for a read.
- iomem_addr_o  out  32  word address; bits [1:0] forced to 0.
- iomem_wdata_o  out  32  write data.
- iomem_rdata_i  in  32  read data, valid when `iomem_ready_i` is high.
- iomem_ready_i  in  1  responder completion.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Command bytes:
  - 0x52 ('R') is followed by addr[7:0], addr[15:8], addr[23:16], addr[31:24].
  - 0x57 ('W') is followed by the same 4 address bytes, then data bytes in little-endian order.
  - Any other byte in IDLE is consumed and dropped; no response is sent. This gives the host a resync mechanism.
- Responses:
  - Write success: 0x06.
  - Read success: 0x06, then rdata[7:0], [15:8], [23:16], [31:24].
  - Timeout on either command: 0x15 only.
- States:
  - IDLE → ADDR on an accepted R or W byte.
  - ADDR (byte counter 0..3) → DATA for W, or → REQ for R, after the 4th byte.
  - DATA (0..3) → REQ after the 4th byte.
  - REQ → BUS when `bus_gnt_i` is sampled high.
  - BUS → RESP on `iomem_valid_o && iomem_ready_i`, or on timeout.
  - RESP → IDLE after the last response byte handshakes.
- `rx_ready_o` = 1 only in IDLE, ADDR and DATA.
- Partial address and data are assembled in shift registers. `iomem_addr_o`, `iomem_wdata_o` and `iomem_wstrb_o` are stable from BUS entry until BUS exit.
- Timeout counter:
  - Cleared on BUS entry.
  - Increments each BUS cycle without `iomem_ready_i`.
  - When it reaches TIMEOUT_CYCLES − 1 with no ready, the state exits to RESP with NAK.
  - `iomem_ready_i` arriving in the same cycle as the timeout wins: the transaction is a success.
- Response byte index 0..4 advances only on `tx_valid_o && tx_ready_i`. `tx_data_o` is stable while `tx_valid_o` is high and `tx_ready_i` is low.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-command discards partial state; no response is sent for it.
- One byte is accepted per cycle on `rx_valid_i && rx_ready_o`. The state update is visible the next cycle.
- `bus_req_o` rises in the cycle after the final command byte is accepted. It stays high through REQ and BUS and falls in the cycle RESP is entered.
- Grant sampled high in cycle N → `iomem_valid_o` = 1 in cycle N+1.
- Completion in cycle M (valid and ready both high):
  - `iomem_rdata_i` is captured at the edge ending cycle M.
  - `iomem_valid_o` = 0, `bus_req_o` = 0 and `tx_valid_o` = 1 with 0x06 in cycle M+1.
- Zero-wait responder (ready in the first valid cycle): `iomem_valid_o` is high for exactly 1 cycle.
- Timeout: `iomem_valid_o` is high for exactly TIMEOUT_CYCLES cycles, then 0x15 is presented the next cycle.
- `tx_valid_o` stays high across consecutive response bytes; with `tx_ready_i` held high, one byte is sent per cycle.
- The first command byte of the next command is accepted no earlier than the cycle after the last response handshake.

## Test plan
- Write: stream 57 10 00 00 00 EF BE AD DE, with the grant given immediately and the responder ready after 2 cycles.
  - Required: one transaction with addr 0x00000010, wdata 0xDEADBEEF, wstrb F.
  - Required: tx 06.
- Read: stream 52 03 00 00 04, with rdata 0x12345678 and a zero-wait responder.
  - Required: addr 0x04000000, since addr[1:0] is masked.
  - Required: valid high for exactly 1 cycle.
  - Required: tx 06 78 56 34 12.
- Grant delay: hold `bus_gnt_i` low for 20 cycles after the command.
  - Required: `bus_req_o` high for those 20 cycles, `iomem_valid_o` low throughout.
  - Required: valid rises exactly 1 cycle after the grant is sampled.
- Timeout: with TIMEOUT_CYCLES=16, send a read and never assert ready.
  - Required: valid high for exactly 16 cycles, then tx 15 only, then `busy_o` = 0.
  - Repeat with ready asserted on the 16th valid cycle. Required: tx 06 plus data.
- Garbage and backpressure: send 00 FF, then a read, with `tx_ready_i` toggling every other cycle.
  - Required: 00 and FF are dropped silently.
  - Required: the read completes with 5 bytes in order, and `tx_data_o` is stable while stalled.
- Reset mid-op: deassert `resetn` after 2 address bytes, then again during BUS.
  - Required: all outputs 0 immediately (asynchronous reset).
  - Required: a subsequent full write succeeds normally.
